// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Debounces N_BTN independent raw push-button inputs and turns them into a
// clean level plus one-clk press / release / auto-repeat pulses.
//
// The raw inputs are synchronized into the clk domain. A slow square-wave
// sample_clk, which is produced in the clk domain by a divider, is turned into
// a one-clk "tick" strobe by edge detection. Every channel FSM only advances
// on tick cycles, so the debounce time and repeat timing are measured in
// sample periods rather than in clk cycles.
//
// Parameters
//   N_BTN            number of button channels
//   DEBOUNCE_SAMPLES consecutive equal samples needed to accept a change (1..15)
//   REPEAT_DELAY     ticks held before the first auto-repeat pulse (1..255)
//   REPEAT_RATE      ticks between subsequent auto-repeat pulses (1..255)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sample_clk   sampling square wave (clk domain, used as a level)
//   btn_raw      raw asynchronous button levels, active high
//   btn_level    debounced level per button
//   btn_press    one-clk pulse when a press is accepted
//   btn_release  one-clk pulse when a release is accepted
//   btn_repeat   one-clk pulse per auto-repeat event while held
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int N_BTN            = 4,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int REPEAT_DELAY     = 8,
    parameter int REPEAT_RATE      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_clk,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    localparam logic [3:0] DS = 4'(DEBOUNCE_SAMPLES);
    localparam logic [7:0] RD = 8'(REPEAT_DELAY);
    localparam logic [7:0] RR = 8'(REPEAT_RATE);

    logic             sample_clk_q;
    logic             tick;
    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] btn_sync;

    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [3:0]       cnt_q   [N_BTN];
    logic [3:0]       cnt_d   [N_BTN];
    logic [7:0]       rep_q   [N_BTN];
    logic [7:0]       rep_d   [N_BTN];
    logic [N_BTN-1:0] rate_q;
    logic [N_BTN-1:0] rate_d;

    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] release_d;
    logic [N_BTN-1:0] repeat_d;

    // One-clk strobe on each rising edge of the sampling square wave.
    assign tick = sample_clk & ~sample_clk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_clk_q <= 1'b0;
            sync_meta    <= '0;
            btn_sync     <= '0;
        end else begin
            sample_clk_q <= sample_clk;
            sync_meta    <= btn_raw;
            btn_sync     <= sync_meta;
        end
    end

    // Per-channel next-state logic. Nothing moves unless tick is high, so a
    // static sample_clk freezes every channel. rate_d low means the next
    // repeat waits REPEAT_DELAY ticks, high means REPEAT_RATE ticks.
    // Leaving RELEASE_CHK back to HELD keeps the repeat counter untouched so
    // a short release glitch does not disturb the repeat cadence.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            rep_d[i]     = rep_q[i];
            rate_d[i]    = rate_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            repeat_d[i]  = 1'b0;

            if (tick) begin
                case (state_q[i])
                    IDLE: begin
                        if (btn_sync[i]) begin
                            if (DEBOUNCE_SAMPLES == 1) begin
                                state_d[i] = HELD;
                                cnt_d[i]   = 4'd0;
                                rep_d[i]   = 8'd0;
                                rate_d[i]  = 1'b0;
                                press_d[i] = 1'b1;
                            end else begin
                                state_d[i] = PRESS_CHK;
                                cnt_d[i]   = 4'd1;
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (btn_sync[i]) begin
                            if (cnt_q[i] + 4'd1 == DS) begin
                                state_d[i] = HELD;
                                cnt_d[i]   = 4'd0;
                                rep_d[i]   = 8'd0;
                                rate_d[i]  = 1'b0;
                                press_d[i] = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 4'd1;
                            end
                        end else begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = 4'd0;
                        end
                    end
                    HELD: begin
                        if (!btn_sync[i]) begin
                            if (DEBOUNCE_SAMPLES == 1) begin
                                state_d[i]   = IDLE;
                                cnt_d[i]     = 4'd0;
                                release_d[i] = 1'b1;
                            end else begin
                                state_d[i] = RELEASE_CHK;
                                cnt_d[i]   = 4'd1;
                            end
                        end else if (rep_q[i] + 8'd1 == (rate_q[i] ? RR : RD)) begin
                            rep_d[i]    = 8'd0;
                            rate_d[i]   = 1'b1;
                            repeat_d[i] = 1'b1;
                        end else begin
                            rep_d[i] = rep_q[i] + 8'd1;
                        end
                    end
                    RELEASE_CHK: begin
                        if (!btn_sync[i]) begin
                            if (cnt_q[i] + 4'd1 == DS) begin
                                state_d[i]   = IDLE;
                                cnt_d[i]     = 4'd0;
                                release_d[i] = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 4'd1;
                            end
                        end else begin
                            state_d[i] = HELD;
                            cnt_d[i]   = 4'd0;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = 4'd0;
                    end
                endcase
            end

            level_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_CHK);
        end
    end

    // Channel state plus registered outputs. Pulses come from the tick-gated
    // next-state logic, so they are high for exactly the one cycle after the
    // tick edge and drop again on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= 4'd0;
                rep_q[i]   <= 8'd0;
            end
            rate_q      <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_repeat  <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                rep_q[i]   <= rep_d[i];
            end
            rate_q      <= rate_d;
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            btn_repeat  <= repeat_d;
        end
    end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_SAMPLES, default 4, consecutive equal samples needed to accept a level change; legal range 1..15.
REQ-003 SHALL have parameter REPEAT_DELAY, default 8, ticks held before the first auto-repeat pulse; legal range 1..255.
REQ-004 SHALL have parameter REPEAT_RATE, default 2, ticks between later auto-repeat pulses; legal range 1..255.
REQ-005 SHALL have port clk  input  1  system clock; all state advances on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port sample_clk  input  1  square-wave sampling clock generated in the clk domain by the frequency divider; used as a level, never as a clock.
REQ-008 SHALL have port btn_raw  input  N_BTN  asynchronous active-high raw button levels.
REQ-009 SHALL have port btn_level  output  N_BTN  debounced level per button.
REQ-010 SHALL have port btn_press  output  N_BTN  one-clk pulse on an accepted press.
REQ-011 SHALL have port btn_release  output  N_BTN  one-clk pulse on an accepted release.
REQ-012 SHALL have port btn_repeat  output  N_BTN  one-clk pulse per auto-repeat event.

Function
REQ-013 SHALL register sample_clk once and form internal tick = sample_clk & ~sample_clk_q, which is high for exactly one clk cycle per sample_clk rising edge.
REQ-014 SHALL pass each btn_raw bit through a 2-flop synchronizer; FSMs SHALL see only the synchronized value.
REQ-015 SHALL change per-channel FSM, sample counter and repeat counter state only on clk edges where tick=1; with sample_clk static, state SHALL be frozen.
REQ-016 SHALL implement per channel the states IDLE, PRESS_CHK, HELD and RELEASE_CHK, with a 4-bit sample counter cnt.
REQ-017 IDLE: sample 1 -> PRESS_CHK with cnt=1; sample 0 -> stay in IDLE.
REQ-018 PRESS_CHK: sample 1 -> cnt+1; on the tick where cnt reaches DEBOUNCE_SAMPLES -> HELD, assert btn_press, clear the repeat counter; sample 0 -> IDLE with cnt=0.
REQ-019 HELD: sample 0 -> RELEASE_CHK with cnt=1; sample 1 -> advance the repeat logic.
REQ-020 RELEASE_CHK: sample 0 -> cnt+1; on the tick where cnt reaches DEBOUNCE_SAMPLES -> IDLE, assert btn_release; sample 1 -> HELD with the repeat counter preserved.
REQ-021 With DEBOUNCE_SAMPLES=1, a single differing sample SHALL complete the transition from IDLE or HELD directly, bypassing the CHK state.
REQ-022 SHALL use an 8-bit repeat counter and a first/rate phase flag; in HELD, the counter increments each tick with sample 1; reaching REPEAT_DELAY (first phase) or REPEAT_RATE (rate phase) asserts btn_repeat, zeroes the counter and sets rate phase.
REQ-023 SHALL reset the phase flag to first on every entry to HELD from PRESS_CHK.
REQ-024 btn_level SHALL be 1 exactly in HELD and RELEASE_CHK.
REQ-025 All outputs SHALL be registered; pulses SHALL be high exactly one clk cycle, in the cycle after the tick edge that caused them.
REQ-026 btn_press and btn_release of one channel SHALL never be high together; channels SHALL be fully independent and may pulse in the same cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force all channels to IDLE, clear cnt, repeat counters, phase flags, synchronizers and sample_clk_q, and drive all outputs to 0.
REQ-028 After rst_n deasserts, a button already held SHALL need DEBOUNCE_SAMPLES full ticks before btn_press, with no spurious btn_release.

Verification
REQ-029 Reset: rst_n=0 with btn_raw=4'hF and sample_clk toggling -> all outputs 0 for the whole reset period.
REQ-030 Clean press, defaults: btn_raw[0]=1 held -> btn_press[0] pulses once, one clk after the 4th tick; btn_level[0]=1 from that cycle on.
REQ-031 Bounce: btn_raw[1] is 1 for 3 ticks, 0 for 1, then 1 -> no pulse until the 4th tick of the second high run, then exactly one btn_press[1].
REQ-032 Auto-repeat: hold btn_raw[2] -> btn_repeat[2] at the 8th tick after HELD entry, then every 2 ticks; none after release.
REQ-033 Release glitch: in HELD, btn_raw[3]=0 for 2 ticks, then 1 -> no btn_release[3]; btn_level[3] stays 1; repeat cadence continues.
REQ-034 Reset mid-hold: rst_n pulsed low while channel 0 is HELD with input still 1 -> outputs 0 at once; btn_press[0] again 4 ticks after rst_n returns high.
